branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
Execute-side branch resolution stage, directly downstream of the fetch/predict stage. It takes each decoded control-transfer instruction with its word-indexed PC, source operands and the fetch-time prediction. It computes the real direction and target, and returns valid_exe, branch_status_exe and jump_addr_exe to fetch for BTB/predictor update and mispredict recovery. On a mispredict it runs a fixed-length flush window and blocks new input until the window ends.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after a mispredict (legal range 1..15)
PC_W, 32, width of PC and target paths

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
in_valid  input  1  decode presents an instruction
in_ready  output  1  unit accepts input this cycle
in_instr  input  32  instruction word
in_pc  input  PC_W  word-indexed PC of in_instr
rs1_val  input  32  rs1 operand
rs2_val  input  32  rs2 operand
pred_taken  input  1  fetch prediction for this instruction
valid_exe  output  1  one-cycle pulse: resolution result valid
branch_status_exe  output  1  1 = taken
jump_addr_exe  output  PC_W  word target if taken, in_pc+1 if not taken
link_valid  output  1  JAL/JALR writeback valid (same cycle as valid_exe)
link_val  output  32  byte return address, (in_pc+1)<<2
mispredict  output  1  branch_status_exe != pred_taken, qualified by valid_exe
illegal_br  output  1  B-opcode with funct3 010/011
flush  output  1  high while in FLUSH

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, counter=0. valid_exe, branch_status_exe, mispredict, link_valid, illegal_br and flush are 0; jump_addr_exe and link_val are 0. Reset mid-flush aborts the flush immediately.
- in_ready = (state==RUN). Accept = in_valid && in_ready. Input arriving while in_ready=0 is ignored and not queued.
- Only opcodes 1100011 (B), 1101111 (JAL) and 1100111 (JALR) produce results. Other accepted opcodes produce no output pulse.
- Latency: 1 cycle. An instruction accepted at edge N drives registered outputs for exactly the cycle after N. All pulse outputs are otherwise 0, and data outputs hold their last value.
- B funct3 conditions, all other funct3 values not taken:
  - 000 taken if equal; 001 taken if not equal.
  - 100 taken if signed less-than; 101 taken if signed greater-or-equal.
  - 110 taken if unsigned less-than; 111 taken if unsigned greater-or-equal.
  - 010/011: not taken, illegal_br=1.
- JAL and JALR are always taken. link_valid=1 for JAL/JALR only.
- Immediates, each sign-extended to 32 bits:
  - B: {i[31],i[7],i[30:25],i[11:8],0}
  - J: {i[31],i[19:12],i[20],i[30:21],0}
  - I: i[31:20]
- Targets, all modulo 2^PC_W (wrap-around):
  - B/JAL: in_pc + (imm >>> 2), arithmetic shift.
  - JALR: ((rs1_val + imm) & ~1) >> 2, logical shift.
  - Not taken: in_pc + 1.
- mispredict = valid_exe && (branch_status_exe != pred_taken).
- FSM: RUN and FLUSH.
  - RUN -> FLUSH at the edge that registers a mispredicting result; counter loads FLUSH_CYCLES.
  - In FLUSH the counter decrements each edge. FLUSH -> RUN at the edge where counter==1.
  - flush is high for exactly FLUSH_CYCLES cycles, starting the same cycle as the mispredict pulse.
- Back-to-back correct predictions are accepted every cycle with no bubble. An instruction presented in the same cycle as the mispredict pulse is rejected (in_ready=0).

Optional Feature:
BRU_STATS_EN:
- Defined: adds outputs stat_branches[31:0] (count of valid_exe pulses) and stat_mispredicts[31:0] (count of mispredict pulses). Both counters saturate at 0xFFFFFFFF and clear on reset.
- Undefined: no stat ports and no counter logic; all other behaviour is identical.

Test Plan:
- BEQ, rs1=rs2=5, in_pc=0x10, imm=+8, pred_taken=1 -> next cycle: valid_exe=1, branch_status_exe=1, jump_addr_exe=0x12, mispredict=0, flush=0, in_ready stays 1.
- BLT, rs1=0xFFFFFFFF, rs2=1, pred_taken=0 -> taken, mispredict=1, flush high for 2 cycles, in_ready=0 for 2 cycles; in_valid during those cycles produces no valid_exe.
- BLTU with the same operands, in_pc=0x20, pred_taken=0 -> not taken, jump_addr_exe=0x21, mispredict=0.
- JALR, rs1=0x103, imm=-2, in_pc=0x40 -> target 0x40 (0x101&~1=0x100, >>2), link_val=0x104, link_valid=1.
- B-opcode with funct3=010 -> illegal_br=1, branch_status_exe=0, jump_addr_exe=in_pc+1.
- rst driven to 0 during the first flush cycle -> flush=0 and in_ready=1 immediately; after release, a JAL at in_pc=0xFFFFFFFF with imm=+4 gives jump_addr_exe=0x00000000 (wrap).

Source files
------------

// File: rtl/branch_resolve_unit_if.sv
// branch_resolve_unit_if: groups the decode-side input handshake and the
// resolution result bus of branch_resolve_unit.
//   master : decode/fetch side (drives instruction, operands, prediction)
//   slave  : branch_resolve_unit (drives in_ready and all resolution outputs)
// Parameter PC_W sets the width of the PC and target paths.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic [31:0]     rs1_val;
  logic [31:0]     rs2_val;
  logic            pred_taken;
  logic            valid_exe;
  logic            branch_status_exe;
  logic [PC_W-1:0] jump_addr_exe;
  logic            link_valid;
  logic [31:0]     link_val;
  logic            mispredict;
  logic            illegal_br;
  logic            flush;

  modport master (
    output in_valid, in_instr, in_pc, rs1_val, rs2_val, pred_taken,
    input  in_ready, valid_exe, branch_status_exe, jump_addr_exe, link_valid, link_val,
           mispredict, illegal_br, flush
  );

  modport slave (
    input  in_valid, in_instr, in_pc, rs1_val, rs2_val, pred_taken,
    output in_ready, valid_exe, branch_status_exe, jump_addr_exe, link_valid, link_val,
           mispredict, illegal_br, flush
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: execute-side resolution of B/JAL/JALR instructions.
// Computes real direction and word target one cycle after acceptance and
// reports mispredicts; a mispredict opens a FLUSH_CYCLES-long flush window
// during which input is refused (in_ready=0).
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-low
//   bus  : branch_resolve_unit_if.slave (input handshake + result outputs)
//   stat_branches / stat_mispredicts : saturating event counters, present
//     only when the BRU_STATS_EN macro is defined.
// Parameters: FLUSH_CYCLES (1..15), PC_W (PC/target width).
module branch_resolve_unit #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned PC_W         = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  branch_resolve_unit_if.slave        bus
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]                 stat_branches,
  output logic [31:0]                 stat_mispredicts
`endif
);

  localparam logic [6:0] OpB    = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic            valid_q, taken_q, link_valid_q, mis_q, illegal_q;
  logic [PC_W-1:0] addr_q;
  logic [31:0]     link_val_q;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [31:0]       imm_b, imm_j, imm_i, off_imm, jalr_word, pc1_32;
  logic signed [31:0] off_sh;
  logic [PC_W-1:0]   pc_plus1, rel_tgt, jalr_tgt;
  logic              accept, res_valid, res_taken, res_illegal, res_link, res_mis;
  logic [PC_W-1:0]   res_addr;
  logic [31:0]       res_link_val;

  assign accept = bus.in_valid && (state_q == StRun);

  always_comb begin
    opcode = bus.in_instr[6:0];
    funct3 = bus.in_instr[14:12];
    imm_b  = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7], bus.in_instr[30:25],
              bus.in_instr[11:8], 1'b0};
    imm_j  = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12], bus.in_instr[20],
              bus.in_instr[30:21], 1'b0};
    imm_i  = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};

    res_valid   = 1'b0;
    res_taken   = 1'b0;
    res_illegal = 1'b0;
    res_link    = 1'b0;
    off_imm     = imm_b;

    case (opcode)
      OpB: begin
        res_valid = 1'b1;
        case (funct3)
          3'b000:         res_taken = (bus.rs1_val == bus.rs2_val);
          3'b001:         res_taken = (bus.rs1_val != bus.rs2_val);
          3'b100:         res_taken = ($signed(bus.rs1_val) <  $signed(bus.rs2_val));
          3'b101:         res_taken = ($signed(bus.rs1_val) >= $signed(bus.rs2_val));
          3'b110:         res_taken = (bus.rs1_val <  bus.rs2_val);
          3'b111:         res_taken = (bus.rs1_val >= bus.rs2_val);
          3'b010, 3'b011: res_illegal = 1'b1;
          default:        res_taken = 1'b0;
        endcase
      end
      OpJal: begin
        res_valid = 1'b1;
        res_taken = 1'b1;
        res_link  = 1'b1;
        off_imm   = imm_j;
      end
      OpJalr: begin
        res_valid = 1'b1;
        res_taken = 1'b1;
        res_link  = 1'b1;
      end
      default: ;
    endcase

    // Byte offsets become word offsets; sign is kept so backward branches work.
    off_sh    = $signed(off_imm) >>> 2;
    rel_tgt   = bus.in_pc + PC_W'(off_sh);
    jalr_word = ((bus.rs1_val + imm_i) & ~32'd1) >> 2;
    jalr_tgt  = PC_W'(jalr_word);
    pc_plus1  = bus.in_pc + PC_W'(1);
    pc1_32    = 32'(pc_plus1);
    res_link_val = pc1_32 << 2;

    if (!res_taken)           res_addr = pc_plus1;
    else if (opcode == OpJalr) res_addr = jalr_tgt;
    else                      res_addr = rel_tgt;

    res_mis = res_taken != bus.pred_taken;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StRun;
      cnt_q        <= 4'd0;
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      link_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      illegal_q    <= 1'b0;
      addr_q       <= '0;
      link_val_q   <= '0;
    end else begin
      // Pulse outputs default low; data outputs keep their last value.
      valid_q      <= 1'b0;
      link_valid_q <= 1'b0;
      mis_q        <= 1'b0;
      illegal_q    <= 1'b0;
      if (accept && res_valid) begin
        valid_q      <= 1'b1;
        taken_q      <= res_taken;
        addr_q       <= res_addr;
        link_valid_q <= res_link;
        mis_q        <= res_mis;
        illegal_q    <= res_illegal;
        if (res_link) link_val_q <= res_link_val;
      end

      case (state_q)
        StRun: begin
          if (accept && res_valid && res_mis) begin
            state_q <= StFlush;
            cnt_q   <= 4'(FLUSH_CYCLES);
          end
        end
        StFlush: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= StRun;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign bus.in_ready          = (state_q == StRun);
  assign bus.flush             = (state_q == StFlush);
  assign bus.valid_exe         = valid_q;
  assign bus.branch_status_exe = taken_q;
  assign bus.jump_addr_exe     = addr_q;
  assign bus.link_valid        = link_valid_q;
  assign bus.link_val          = link_val_q;
  assign bus.mispredict        = mis_q;
  assign bus.illegal_br        = illegal_q;

`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_mis_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      if (valid_q && (stat_br_q != '1))  stat_br_q  <= stat_br_q + 32'd1;
      if (mis_q && (stat_mis_q != '1))   stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed instructions push their
// hand-computed results into a queue; a negedge monitor pops and compares
// whenever valid_exe is seen. Flush/reset timing is checked directly.
module tb_branch_resolve_unit;
  localparam int unsigned PC_W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.PC_W(PC_W)) bus_if ();

`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit #(.FLUSH_CYCLES(2), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
`ifdef BRU_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    logic        taken;
    logic [31:0] addr;
    logic        mis;
    logic        link;
    logic [31:0] lval;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm);
    return {imm, 5'd1, 3'b000, 5'd1, 7'b1100111};
  endfunction

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic pred);
    bus_if.in_valid   = 1'b1;
    bus_if.in_instr   = instr;
    bus_if.in_pc      = pc;
    bus_if.rs1_val    = a;
    bus_if.rs2_val    = b;
    bus_if.pred_taken = pred;
  endtask

  task automatic idle();
    bus_if.in_valid = 1'b0;
  endtask

  task automatic push(input logic taken, input logic [31:0] addr, input logic mis,
                      input logic link, input logic [31:0] lval, input logic ill);
    exp_t e;
    e.taken = taken; e.addr = addr; e.mis = mis;
    e.link = link;   e.lval = lval; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid_exe pulse must match the oldest expected result.
  always @(negedge clk) begin : mon
    exp_t e;
    if (bus_if.valid_exe === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid_exe", 32'(bus_if.valid_exe), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("branch_status_exe", 32'(bus_if.branch_status_exe), 32'(e.taken));
        chk("jump_addr_exe", bus_if.jump_addr_exe, e.addr);
        chk("mispredict", 32'(bus_if.mispredict), 32'(e.mis));
        chk("link_valid", 32'(bus_if.link_valid), 32'(e.link));
        chk("illegal_br", 32'(bus_if.illegal_br), 32'(e.ill));
        if (e.link) chk("link_val", bus_if.link_val, e.lval);
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus_if.in_valid = 1'b0;
    bus_if.in_instr = 32'h0;
    bus_if.in_pc = 32'h0;
    bus_if.rs1_val = 32'h0;
    bus_if.rs2_val = 32'h0;
    bus_if.pred_taken = 1'b0;
    #2;
    chk("rst_valid_exe", 32'(bus_if.valid_exe), 32'd0);
    chk("rst_branch_status", 32'(bus_if.branch_status_exe), 32'd0);
    chk("rst_mispredict", 32'(bus_if.mispredict), 32'd0);
    chk("rst_link_valid", 32'(bus_if.link_valid), 32'd0);
    chk("rst_illegal_br", 32'(bus_if.illegal_br), 32'd0);
    chk("rst_flush", 32'(bus_if.flush), 32'd0);
    chk("rst_jump_addr", bus_if.jump_addr_exe, 32'd0);
    chk("rst_link_val", bus_if.link_val, 32'd0);
    chk("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    step();

    // Back-to-back correctly predicted branches, one per cycle.
    issue(enc_b(3'b000, 13'h008), 32'h10, 32'd5, 32'd5, 1'b1);          // BEQ taken
    push(1'b1, 32'h12, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk("beq_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("beq_flush", 32'(bus_if.flush), 32'd0);
    issue(enc_b(3'b001, 13'h008), 32'h30, 32'd5, 32'd5, 1'b0);          // BNE not taken
    push(1'b0, 32'h31, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    issue(enc_b(3'b101, 13'h1FF0), 32'h50, 32'd1, 32'hFFFF_FFFF, 1'b1); // BGE 1 >= -1
    push(1'b1, 32'h4C, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    issue(enc_b(3'b111, 13'h008), 32'h60, 32'd1, 32'hFFFF_FFFF, 1'b0);  // BGEU not taken
    push(1'b0, 32'h61, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    issue(enc_b(3'b110, 13'h008), 32'h20, 32'hFFFF_FFFF, 32'd1, 1'b0);  // BLTU not taken
    push(1'b0, 32'h21, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    issue(enc_b(3'b010, 13'h008), 32'h70, 32'd3, 32'd3, 1'b0);          // illegal funct3
    push(1'b0, 32'h71, 1'b0, 1'b0, 32'h0, 1'b1);
    step();
    issue(enc_i(12'hFFE), 32'h40, 32'h103, 32'h0, 1'b1);                // JALR
    push(1'b1, 32'h40, 1'b0, 1'b1, 32'h104, 1'b0);
    step();
    issue(32'h0000_0013, 32'h44, 32'h0, 32'h0, 1'b0);                   // non-branch
    step();
    chk("nonbr_no_valid", 32'(bus_if.valid_exe), 32'd0);
    chk("nonbr_addr_hold", bus_if.jump_addr_exe, 32'h40);
    chk("nonbr_link_hold", bus_if.link_val, 32'h104);

    // Mispredict: BLT -1 < 1 taken, predicted not taken.
    issue(enc_b(3'b100, 13'h00C), 32'h80, 32'hFFFF_FFFF, 32'd1, 1'b0);
    push(1'b1, 32'h83, 1'b1, 1'b0, 32'h0, 1'b0);
    step();
    chk("mis_pulse", 32'(bus_if.mispredict), 32'd1);
    chk("mis_flush0", 32'(bus_if.flush), 32'd1);
    chk("mis_in_ready0", 32'(bus_if.in_ready), 32'd0);
    issue(enc_b(3'b000, 13'h008), 32'hA0, 32'd5, 32'd5, 1'b1);          // must be ignored
    step();
    chk("mis_flush1", 32'(bus_if.flush), 32'd1);
    chk("mis_in_ready1", 32'(bus_if.in_ready), 32'd0);
    chk("mis_pulse_end", 32'(bus_if.mispredict), 32'd0);
    step();
    chk("mis_flush_end", 32'(bus_if.flush), 32'd0);
    chk("mis_in_ready_back", 32'(bus_if.in_ready), 32'd1);
    idle();
    step();

    // Mispredict followed by reset during the first flush cycle.
    issue(enc_b(3'b000, 13'h008), 32'h90, 32'd1, 32'd2, 1'b1);
    step();
    idle();
    chk("rf_mispredict", 32'(bus_if.mispredict), 32'd1);
    chk("rf_flush", 32'(bus_if.flush), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rf_flush_cleared", 32'(bus_if.flush), 32'd0);
    chk("rf_in_ready", 32'(bus_if.in_ready), 32'd1);
    chk("rf_valid_cleared", 32'(bus_if.valid_exe), 32'd0);
    chk("rf_mis_cleared", 32'(bus_if.mispredict), 32'd0);
    chk("rf_addr_cleared", bus_if.jump_addr_exe, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    step();

    // JAL with PC wrap-around.
    issue(enc_j(21'h000004), 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
    push(1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0, 1'b0);
    step();
    idle();
    step();
    step();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
